// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: core (m0) has fixed priority, the loader (m1) is granted after MAX_HOLD m0 wins.
// Grant is combinational, the command is registered and read data returns RD_LATENCY+2 cycles after grant.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [3:0]          r_hold_cnt;
    logic                w_hold_max;
    logic                w_m0_gnt;
    logic                w_m1_gnt;
    logic                w_gnt;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_rd_push;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [RD_LATENCY:0] r_pipe_vld;
    logic [RD_LATENCY:0] r_pipe_own;
    logic                r_m0_rvalid;
    logic                r_m1_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    // Grants are gated by reset so every output reads 0 while resetn is low.
    assign w_hold_max  = (r_hold_cnt == 4'(MAX_HOLD));
    assign w_m0_gnt    = resetn & m0_req & ~(m1_req & w_hold_max);
    assign w_m1_gnt    = resetn & m1_req & ~w_m0_gnt;
    assign w_gnt       = w_m0_gnt | w_m1_gnt;
    assign w_sel_we    = w_m1_gnt ? m1_we    : m0_we;
    assign w_sel_addr  = w_m1_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_m1_gnt ? m1_wdata : m0_wdata;
    assign w_rd_push   = w_gnt & ~w_sel_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_cnt <= '0;
        end else if (!m1_req || w_m1_gnt) begin
            r_hold_cnt <= '0;
        end else if (w_m0_gnt && !w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_gnt;
            r_mem_we <= w_gnt & w_sel_we;
            if (w_gnt) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
        end
    end

    // Stage k holds the read issued k+1 cycles ago; the last stage lines up with valid mem_rdata.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pipe_vld  <= '0;
            r_pipe_own  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_pipe_vld  <= {r_pipe_vld[RD_LATENCY-1:0], w_rd_push};
            r_pipe_own  <= {r_pipe_own[RD_LATENCY-1:0], w_m1_gnt};
            r_m0_rvalid <= r_pipe_vld[RD_LATENCY] & ~r_pipe_own[RD_LATENCY];
            r_m1_rvalid <= r_pipe_vld[RD_LATENCY] &  r_pipe_own[RD_LATENCY];
            if (r_pipe_vld[RD_LATENCY]) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_rdata;
    assign m1_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 1;
    localparam int MAX_HOLD   = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous RAM stand-in with one cycle of read latency.
    logic [DATA_W-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: shadow memory updated in grant order, queue of expected returns.
    typedef struct { int due; bit own; logic [DATA_W-1:0] dat; } rd_t;
    logic [DATA_W-1:0] shadow [0:65535];
    rd_t               rdq[$];
    int                hold;
    logic              e_en, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    bit                last_g0, last_g1;
    int n_chk = 0, n_fail = 0;
    int n_rgnt = 0, n_rv = 0, n_m1g = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic eval();
        bit g0, g1, rv0, rv1, we;
        logic [DATA_W-1:0] d0, d1, wd;
        logic [ADDR_W-1:0] a;
        rd_t r;
        #1;
        g0 = m0_req && !(m1_req && hold == MAX_HOLD);
        g1 = m1_req && !g0;
        check("m0_gnt", 32'(m0_gnt), 32'(g0));
        check("m1_gnt", 32'(m1_gnt), 32'(g1));
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        rv0 = 0; rv1 = 0; d0 = '0; d1 = '0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            r = rdq.pop_front();
            if (r.own) begin rv1 = 1; d1 = r.dat; end
            else       begin rv0 = 1; d0 = r.dat; end
        end
        check("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
        if (rv0) check("m0_rdata", 32'(m0_rdata), 32'(d0));
        if (rv1) check("m1_rdata", 32'(m1_rdata), 32'(d1));
        n_rv += int'(m0_rvalid) + int'(m1_rvalid);
        e_en = g0 || g1;
        e_we = 1'b0;
        if (g0 || g1) begin
            we = g1 ? m1_we : m0_we;
            a  = g1 ? m1_addr : m0_addr;
            wd = g1 ? m1_wdata : m0_wdata;
            e_we = we; e_addr = a; e_wdata = wd;
            if (we) shadow[a] = wd;
            else begin
                r.due = cyc + 2 + RD_LATENCY; r.own = g1; r.dat = shadow[a];
                rdq.push_back(r);
                n_rgnt++;
            end
            if (g1) n_m1g++;
        end
        if (!m1_req)     hold = 0;
        else if (g0)     hold = (hold < MAX_HOLD) ? hold + 1 : hold;
        else             hold = 0;
        last_g0 = g0; last_g1 = g1;
        @(negedge clk);
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit r1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        eval();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    // Asserts reset for one cycle from a negedge and checks outputs clear immediately.
    task automatic pulse_reset();
        resetn = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("rst_m0_rdata", 32'(m0_rdata), 32'd0);
        check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
        rdq.delete();
        hold = 0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    bit                p_req [2];
    bit                p_we  [2];
    logic [ADDR_W-1:0] p_addr[2];
    logic [DATA_W-1:0] p_wd  [2];

    initial begin
        resetn = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        ram[16'h8000] = 8'hA9; shadow[16'h8000] = 8'hA9;
        ram[16'h0010] = 8'h11; shadow[16'h0010] = 8'h11;
        ram[16'h0020] = 8'h22; shadow[16'h0020] = 8'h22;
        @(negedge clk);
        pulse_reset();
        idle(7);

        // Single core read of 0x8000.
        drive(1, 0, 16'h8000, 8'h00, 0, 0, 16'h0, 8'h0);
        idle(4);

        // Loader write then read-back of the same address.
        drive(0, 0, 16'h0, 8'h0, 1, 1, 16'h0200, 8'h55);
        drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0200, 8'h00);
        idle(4);

        // Continuous contention: 4 core grants then 1 loader grant.
        n_m1g = 0;
        for (int i = 0; i < 20; i++) drive(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0);
        check("contention_m1_grants", 32'(n_m1g), 32'd4);
        idle(4);

        // Alternating single-requester reads.
        n_rgnt = 0; n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0);
            drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0);
        end
        idle(4);
        check("alt_read_grants", 32'(n_rgnt), 32'd16);
        check("alt_rvalid_count", 32'(n_rv), 32'(n_rgnt));

        // Reset with two reads in flight, then a normal read.
        drive(1, 0, 16'h8000, 8'h0, 0, 0, 16'h0, 8'h0);
        drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0);
        pulse_reset();
        idle(4);
        drive(1, 0, 16'h8000, 8'h0, 0, 0, 16'h0, 8'h0);
        idle(4);

        // Loader request dropped before its turn; hold count must restart afterwards.
        n_m1g = 0;
        drive(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0);
        drive(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0);
        drive(1, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0);
        check("cancel_no_m1_gnt", 32'(n_m1g), 32'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0300, 8'h77);
        check("cancel_hold_restart", 32'(n_m1g), 32'd0);
        drive(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0300, 8'h77);
        check("cancel_m1_after_hold", 32'(n_m1g), 32'd1);
        idle(4);

        // Random traffic obeying the hold-until-grant rule, with occasional cancellation.
        p_req[0] = 0; p_req[1] = 0;
        for (int c = 0; c < 800; c++) begin
            drive(p_req[0], p_we[0], p_addr[0], p_wd[0], p_req[1], p_we[1], p_addr[1], p_wd[1]);
            for (int k = 0; k < 2; k++) begin
                if (!p_req[k] || (k == 0 ? last_g0 : last_g1)) begin
                    p_req[k]  = ($urandom_range(0, 3) != 0);
                    p_we[k]   = ($urandom_range(0, 2) == 0);
                    p_addr[k] = 16'($urandom_range(0, 7));
                    p_wd[k]   = 8'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    p_req[k] = 0;
                end
            end
        end
        idle(5);
        check("final_queue_drained", 32'(rdq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
